// File: rtl/fast_pat_sequencer_if.sv
// rtl/fast_pat_sequencer_if.sv - host config, control and frame handshake bundle for fast_pat_sequencer
interface fast_pat_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ADDR_W-1:0] cfg_pat_stride;
  logic [PAT_W-1:0]  cfg_pat_num;
  logic [CNT_W-1:0]  cfg_repeat;
  logic [CNT_W-1:0]  cfg_gap;
  logic              cfg_loop;
  logic              start;
  logic              stop;
  logic              frame_busy;
  logic              frame_trig;
  logic [ADDR_W-1:0] pat_addr;
  logic [PAT_W-1:0]  pat_index;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_err;

  modport master (
    output cfg_base_addr, cfg_pat_stride, cfg_pat_num, cfg_repeat, cfg_gap, cfg_loop,
    output start, stop, frame_busy,
    input  frame_trig, pat_addr, pat_index, seq_busy, seq_done, seq_err
  );

  modport slave (
    input  cfg_base_addr, cfg_pat_stride, cfg_pat_num, cfg_repeat, cfg_gap, cfg_loop,
    input  start, stop, frame_busy,
    output frame_trig, pat_addr, pat_index, seq_busy, seq_done, seq_err
  );
endinterface

// File: rtl/fast_pat_sequencer.sv
// rtl/fast_pat_sequencer.sv - plays a programmed pattern list, one frame trigger per repeat, with gap and loop
module fast_pat_sequencer #(
  parameter int ADDR_W       = 11,
  parameter int PAT_W        = 8,
  parameter int CNT_W        = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fast_pat_sequencer_if.slave  bus
);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t            state_q, state_d;
  logic              arm_ph_q, arm_ph_d;
  logic              stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [PAT_W-1:0]  pat_num_q, pat_num_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              loop_q, loop_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              trig_q, trig_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PAT_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  cnt_next;
  logic              go_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arm_ph_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      base_q      <= '0;
      stride_q    <= '0;
      pat_num_q   <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      loop_q      <= 1'b0;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
      tmr_q       <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      arm_ph_q    <= arm_ph_d;
      stop_pend_q <= stop_pend_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      pat_num_q   <= pat_num_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      loop_q      <= loop_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tmr_q       <= tmr_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      index_q     <= index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    arm_ph_d    = 1'b0;
    stop_pend_d = stop_pend_q;
    base_d      = base_q;
    stride_d    = stride_q;
    pat_num_d   = pat_num_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    loop_d      = loop_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tmr_d       = tmr_q;
    trig_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    addr_d      = addr_q;
    index_d     = index_q;
    cnt_next    = frame_cnt_q + 1'b1;
    go_next     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          if (bus.cfg_pat_num == '0) begin
            err_d = 1'b1;
          end else begin
            base_d      = bus.cfg_base_addr;
            stride_d    = bus.cfg_pat_stride;
            pat_num_d   = bus.cfg_pat_num;
            rep_d       = (bus.cfg_repeat == '0) ? CNT_W'(1) : bus.cfg_repeat;
            gap_d       = bus.cfg_gap;
            loop_d      = bus.cfg_loop;
            addr_d      = bus.cfg_base_addr;
            index_d     = '0;
            frame_cnt_d = '0;
            err_d       = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = ARM;
          end
        end
      end

      // First ARM cycle lets pat_addr settle at the fetcher before the trigger fires.
      ARM: begin
        if (bus.stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!arm_ph_q) begin
          arm_ph_d = 1'b1;
        end else if (!bus.frame_busy) begin
          trig_d  = 1'b1;
          tmr_d   = '0;
          state_d = WAIT_BUSY;
        end else begin
          arm_ph_d = 1'b1;
        end
      end

      WAIT_BUSY: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (bus.frame_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (!bus.frame_busy) begin
          if (stop_pend_q || bus.stop) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (cnt_next < rep_q) begin
            frame_cnt_d = cnt_next;
            go_next     = 1'b1;
          end else begin
            frame_cnt_d = '0;
            if (index_q == pat_num_q - 1'b1) begin
              if (loop_q) begin
                index_d = '0;
                addr_d  = base_q;
                go_next = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              index_d = index_q + 1'b1;
              addr_d  = addr_q + stride_q;
              go_next = 1'b1;
            end
          end
          if (go_next) begin
            if (gap_q == '0) begin
              state_d = ARM;
            end else begin
              gap_cnt_d = gap_q - 1'b1;
              state_d   = GAP;
            end
          end
        end
      end

      GAP: begin
        if (bus.stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = ARM;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.frame_trig = trig_q;
  assign bus.seq_done   = done_q;
  assign bus.seq_err    = err_q;
  assign bus.seq_busy   = busy_q;
  assign bus.pat_addr   = addr_q;
  assign bus.pat_index  = index_q;
endmodule

// File: tb/tb_fast_pat_sequencer.sv
// tb/tb_fast_pat_sequencer.sv - directed self-checking bench for fast_pat_sequencer
module tb_fast_pat_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   extra_trig = 0;

  fast_pat_sequencer_if #(.ADDR_W(11), .PAT_W(8), .CNT_W(16)) bus();

  fast_pat_sequencer #(.ADDR_W(11), .PAT_W(8), .CNT_W(16), .BUSY_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int base, input int stride, input int num,
                         input int rep, input int gap, input bit loop_en);
    bus.cfg_base_addr  = 11'(base);
    bus.cfg_pat_stride = 11'(stride);
    bus.cfg_pat_num    = 8'(num);
    bus.cfg_repeat     = 16'(rep);
    bus.cfg_gap        = 16'(gap);
    bus.cfg_loop       = loop_en;
  endtask

  task automatic pulse_start(output int k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
  endtask

  task automatic run_frame(input int len, input bit do_stop,
                           output int t, output int addr, output int idx, output int j);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_trig) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL trig_wait: got no frame_trig expected one within 300 cycles");
      t = -1; addr = -1; idx = -1; j = cyc;
    end else begin
      t = cyc;
      addr = int'(bus.pat_addr);
      idx = int'(bus.pat_index);
      bus.frame_busy = 1'b1;
      for (int i = 1; i <= len; i++) begin
        @(negedge clk);
        if (bus.frame_trig) extra_trig++;
        bus.stop = (do_stop && i == 1);
      end
      bus.stop = 1'b0;
      bus.frame_busy = 1'b0;
      j = t + len + 1;
    end
  endtask

  task automatic wait_done(output int d);
    bit seen = 1'b0;
    d = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.seq_done) begin
        seen = 1'b1;
        d = cyc;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k, t, a, x, j, pj, d, cnt;
    int exp_a1[6];
    exp_a1 = '{32'h010, 32'h010, 32'h030, 32'h030, 32'h050, 32'h050};
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.frame_busy = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_trig", bus.frame_trig, 0);
    check("rst_busy", bus.seq_busy, 0);
    check("rst_done", bus.seq_done, 0);
    check("rst_err", bus.seq_err, 0);
    check("rst_index", bus.pat_index, 0);
    check("rst_addr", bus.pat_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal start with zero patterns.
    set_cfg(16, 16, 0, 1, 0, 0);
    pulse_start(k);
    @(negedge clk);
    check("zero_num_err", bus.seq_err, 1);
    check("zero_num_busy", bus.seq_busy, 0);

    // start and stop together: stop wins.
    set_cfg(16, 16, 2, 1, 0, 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.seq_busy || bus.frame_trig) cnt++;
    end
    check("start_stop_idle", cnt, 0);
    check("start_stop_err_kept", bus.seq_err, 1);

    // Three patterns, two repeats, gap 4, no loop; cfg scrambled after start.
    set_cfg(32'h010, 32'h020, 3, 2, 4, 0);
    pulse_start(k);
    check("t1_busy", bus.seq_busy, 1);
    check("t1_err_clear", bus.seq_err, 0);
    set_cfg(32'h555, 32'h001, 0, 9, 0, 1);
    pj = 0;
    extra_trig = 0;
    for (int f = 0; f < 6; f++) begin
      if (f == 3) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      run_frame(3 + f, 1'b0, t, a, x, j);
      check($sformatf("t1_addr%0d", f), a, exp_a1[f]);
      check($sformatf("t1_index%0d", f), x, f / 2);
      if (f == 0) check("t1_first_trig", t, k + 2);
      else check($sformatf("t1_spacing%0d", f), t, pj + 6);
      pj = j;
    end
    wait_done(d);
    check("t1_done_cycle", d, pj);
    check("t1_done_busy", bus.seq_busy, 0);
    check("t1_single_trig", extra_trig, 0);

    // Looping two patterns, repeat 0, stop during the 5th frame.
    set_cfg(32'h100, 32'h008, 2, 0, 0, 1);
    pulse_start(k);
    for (int f = 0; f < 5; f++) begin
      run_frame(2, f == 4, t, a, x, j);
      check($sformatf("t2_index%0d", f), x, f % 2);
      check($sformatf("t2_addr%0d", f), a, (f % 2) ? 32'h108 : 32'h100);
      if (f > 0) check($sformatf("t2_spacing%0d", f), t, pj + 2);
      pj = j;
    end
    wait_done(d);
    check("t2_stop_done", d, pj);
    check("t2_no_advance", bus.pat_index, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.frame_trig) cnt++;
    end
    check("t2_no_trig_after_stop", cnt, 0);

    // Address wrap.
    set_cfg(32'h7F0, 32'h020, 2, 1, 1, 0);
    pulse_start(k);
    run_frame(2, 1'b0, t, a, x, j);
    check("t3_addr0", a, 32'h7F0);
    pj = j;
    run_frame(2, 1'b0, t, a, x, j);
    check("t3_addr_wrap", a, 32'h010);
    check("t3_spacing", t, pj + 3);
    wait_done(d);
    check("t3_done", d, j);

    // frame_busy never rises.
    set_cfg(32'h040, 32'h010, 1, 1, 0, 0);
    pulse_start(k);
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (bus.frame_trig) t = cyc;
    end
    check("t4_trig", t, k + 2);
    wait_done(d);
    check("t4_timeout_cycle", d, t + 64);
    check("t4_err", bus.seq_err, 1);
    check("t4_busy", bus.seq_busy, 0);

    // Reset during GAP, then restart.
    set_cfg(32'h300, 32'h010, 2, 1, 20, 0);
    pulse_start(k);
    run_frame(3, 1'b0, t, a, x, j);
    repeat (5) @(negedge clk);
    check("t5_in_gap_busy", bus.seq_busy, 1);
    check("t5_in_gap_index", bus.pat_index, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", bus.seq_busy, 0);
    check("t5_rst_index", bus.pat_index, 0);
    check("t5_rst_addr", bus.pat_addr, 0);
    check("t5_rst_err", bus.seq_err, 0);
    check("t5_rst_trig", bus.frame_trig, 0);
    check("t5_rst_done", bus.seq_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_cfg(32'h200, 32'h010, 2, 1, 0, 0);
    pulse_start(k);
    run_frame(2, 1'b0, t, a, x, j);
    check("t5_restart_trig", t, k + 2);
    check("t5_restart_index", x, 0);
    check("t5_restart_addr", a, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
